vga_fb_arbiter: RTL and testbench

- Shares one single-port synchronous framebuffer RAM between two requesters: VGA scanout, which has hard real-time priority, and the CPU/datapath load-store port.
- Sits between the VGA timing generator (hcount/vcount/bright, with a pixel strobe at half of clk) and the framebuffer BRAM.
- Time-slots memory access per pixel period and returns the pixel word to the colour output stage.
- Provides a req/ack handshake to the CPU side.

---
 rtl/vga_fb_arbiter.sv | 130 +++++++++++++
 tb/tb_vga_fb_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares a single-port synchronous framebuffer RAM between
// VGA scanout (hard priority) and a CPU load/store port.
//
// Ports:
//   clk, reset            system clock (2x pixel rate), synchronous active-high reset
//   pix_en                strobe on the first clk of each pixel period (display slot)
//   hcount, vcount        current scan position; bright flags the visible region
//   cpu_req/we/addr/wdata CPU request, held stable until cpu_ack
//   cpu_ack, cpu_rdata    one-cycle completion pulse and read data
//   mem_addr/we/wdata     RAM command, driven in the slot that owns the cycle
//   mem_rdata             RAM read data, one clk after address
//   pix_data, pix_valid   scanout word, two clk after the display slot
module vga_fb_arbiter #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned FB_WIDTH    = 160,
  parameter int unsigned SCALE_SHIFT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              bright,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid
);

  typedef enum logic [1:0] {C_IDLE, C_GRANT, C_ACK} cpu_state_t;
  typedef enum logic [1:0] {SCAN_IDLE, SCAN_FETCH, SCAN_BLANK} scan_state_t;

  cpu_state_t        cpu_state;
  cpu_state_t        cpu_phase;
  scan_state_t       scan_state;
  logic              disp_slot;
  logic              cpu_slot;
  logic              grant;
  logic              ack_rd;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] wdata_hold;
  logic [DATA_W-1:0] rdata_hold;
  logic [31:0]       disp_addr_full;

  // Slot decode and memory command mux. The grant is decided in the same
  // cycle the CPU drives the RAM so that a grant can never spill into the
  // following (possibly visible) display slot.
  always_comb begin
    disp_slot      = !reset && pix_en && bright;
    cpu_slot       = !reset && !disp_slot;
    grant          = cpu_slot && cpu_req && (cpu_state == C_IDLE);
    cpu_phase      = grant ? C_GRANT : cpu_state;
    disp_addr_full = 32'(vcount >> SCALE_SHIFT) * 32'(FB_WIDTH)
                   + 32'(hcount >> SCALE_SHIFT);

    mem_addr  = addr_hold;
    mem_we    = 1'b0;
    mem_wdata = wdata_hold;
    if (reset) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (disp_slot) begin
      mem_addr = ADDR_W'(disp_addr_full);
    end else if (cpu_phase == C_GRANT) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_wdata = cpu_wdata;
    end

    // Read data arrives during the ack cycle; pass it through, then hold it.
    cpu_rdata = (cpu_ack && ack_rd) ? mem_rdata : rdata_hold;
  end

  // CPU handshake FSM, scanout return pipeline and held memory command.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_state  <= C_IDLE;
      scan_state <= SCAN_IDLE;
      cpu_ack    <= 1'b0;
      ack_rd     <= 1'b0;
      rdata_hold <= '0;
      pix_data   <= '0;
      pix_valid  <= 1'b0;
      addr_hold  <= '0;
      wdata_hold <= '0;
    end else begin
      addr_hold  <= mem_addr;
      wdata_hold <= mem_wdata;

      case (cpu_state)
        C_IDLE:  cpu_state <= grant ? C_ACK : C_IDLE;
        C_ACK:   cpu_state <= C_IDLE;
        default: cpu_state <= C_IDLE;
      endcase
      cpu_ack <= grant;
      ack_rd  <= grant && !cpu_we;
      if (cpu_ack && ack_rd) begin
        rdata_hold <= mem_rdata;
      end

      if (pix_en) begin
        scan_state <= bright ? SCAN_FETCH : SCAN_BLANK;
      end else begin
        scan_state <= SCAN_IDLE;
      end

      case (scan_state)
        SCAN_FETCH: begin
          pix_data  <= mem_rdata;
          pix_valid <= 1'b1;
        end
        SCAN_BLANK: begin
          pix_data  <= '0;
          pix_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Testbench for vga_fb_arbiter: directed scenarios followed by randomized
// traffic, all checked each cycle against a transaction-level model.
module tb_vga_fb_arbiter;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 15;
  localparam int unsigned FBW = 160;
  localparam int unsigned SS  = 2;
  localparam int unsigned MEM_DEPTH = 32'(1) << AW;

  logic          clk = 1'b0;
  logic          reset, pix_en, bright;
  logic [9:0]    hcount, vcount;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] pix_data;
  logic          pix_valid;

  always #5 clk = ~clk;

  vga_fb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .FB_WIDTH(FBW), .SCALE_SHIFT(SS)) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
    .bright(bright), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_data(pix_data), .pix_valid(pix_valid)
  );

  // Behavioural single-port synchronous RAM.
  logic [DW-1:0] ram [MEM_DEPTH];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model state.
  logic [DW-1:0] model_mem [MEM_DEPTH];
  int            cyc = 0;
  int            last_grant = -10;
  bit            ack_pend = 0;
  bit            ack_is_rd = 0;
  logic [DW-1:0] ack_data = '0;
  logic [DW-1:0] exp_rdata = '0;
  logic [AW-1:0] exp_addr_hold = '0;
  bit            pset [4];
  bit            pv [4];
  logic [DW-1:0] pd [4];
  bit            exp_pv = 0;
  logic [DW-1:0] exp_pd = '0;
  bit            chk = 0;

  int n_assert = 0;
  int n_fail   = 0;
  int ack_q [$];
  int we_count;
  int grant_count;

  // Samples of the most recent cycle for directed checks.
  bit            last_ack;
  logic [AW-1:0] s_addr;
  logic          s_we;
  logic [DW-1:0] s_rdata;
  logic [DW-1:0] s_pix;
  logic          s_pv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs are already driven; sample at negedge, compare
  // against the model, advance the model, then move to posedge+1.
  task automatic step();
    bit            d, g, ack_now;
    logic [AW-1:0] da, ea;
    logic          ewe;
    @(negedge clk);
    d  = !reset && pix_en && bright;
    da = AW'((32'(vcount) / (32'(1) << SS)) * FBW + 32'(hcount) / (32'(1) << SS));
    g  = !reset && cpu_req && !d && (cyc != last_grant + 1);
    ack_now = ack_pend;
    if (reset)  ea = '0;
    else if (d) ea = da;
    else if (g) ea = cpu_addr;
    else        ea = exp_addr_hold;
    ewe = g && cpu_we;
    if (pset[cyc % 4]) begin
      exp_pv = pv[cyc % 4];
      exp_pd = pd[cyc % 4];
      pset[cyc % 4] = 0;
    end

    if (chk) begin
      check("mem_we", 32'(mem_we), 32'(ewe));
      check("mem_addr", 32'(mem_addr), 32'(ea));
      if (ewe) check("mem_wdata", 32'(mem_wdata), 32'(cpu_wdata));
      check("cpu_ack", 32'(cpu_ack), 32'(ack_now));
      if (ack_now && ack_is_rd) check("cpu_rdata_ack", 32'(cpu_rdata), 32'(ack_data));
      else                      check("cpu_rdata_hold", 32'(cpu_rdata), 32'(exp_rdata));
      check("pix_valid", 32'(pix_valid), 32'(exp_pv));
      check("pix_data", 32'(pix_data), 32'(exp_pd));
    end

    last_ack = ack_now;
    s_addr = mem_addr; s_we = mem_we; s_rdata = cpu_rdata; s_pix = pix_data; s_pv = pix_valid;
    if (mem_we) we_count++;
    if (ack_now) ack_q.push_back(cyc);
    if (ack_now && ack_is_rd) exp_rdata = ack_data;
    ack_pend = 0;

    if (!reset && pix_en) begin
      pset[(cyc + 2) % 4] = 1;
      pv[(cyc + 2) % 4]   = bright;
      pd[(cyc + 2) % 4]   = bright ? model_mem[da] : '0;
    end
    if (g) begin
      grant_count++;
      last_grant = cyc;
      ack_pend   = 1;
      ack_is_rd  = !cpu_we;
      ack_data   = model_mem[cpu_addr];
      if (cpu_we) model_mem[cpu_addr] = cpu_wdata;
    end
    exp_addr_hold = ea;
    if (reset) begin
      exp_rdata = '0;
      exp_pv = 0;
      exp_pd = '0;
      pset[(cyc + 1) % 4] = 0;
      pset[(cyc + 2) % 4] = 0;
      last_grant = -10;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, k, drops, stuck;
    for (int i = 0; i < 4; i++) pset[i] = 0;
    for (int i = 0; i < int'(MEM_DEPTH); i++) begin
      ram[i]       = DW'($urandom);
      model_mem[i] = ram[i];
    end
    ram[162] = 16'hABCD; model_mem[162] = 16'hABCD;
    ram[100] = 16'h1234; model_mem[100] = 16'h1234;

    reset = 1; pix_en = 0; bright = 0; hcount = '0; vcount = '0;
    cpu_req = 1; cpu_we = 0; cpu_addr = AW'(5); cpu_wdata = '0;
    #1;

    // Reset with a request held: no ack until after release.
    step(); chk = 1;
    step(); step();
    check("reset_no_ack", 32'(ack_q.size()), 32'd0);
    reset = 0;
    s = cyc;
    for (int i = 0; i < 4; i++) begin
      step();
      if (last_ack) cpu_req = 0;
    end
    check("first_ack_count", 32'(ack_q.size()), 32'd1);
    if (ack_q.size() > 0) check("first_ack_cycle", 32'(ack_q[0] - s), 32'd1);

    // Scanout addressing and fixed two-clk return latency.
    bright = 1; hcount = 10'd8; vcount = 10'd4; pix_en = 1;
    step();
    check("scan_addr", 32'(s_addr), 32'd162);
    check("scan_we", 32'(s_we), 32'd0);
    pix_en = 0; step();
    pix_en = 1; hcount = 10'd12; step();
    check("scan_pix", 32'(s_pix), 32'hABCD);
    check("scan_pv", 32'(s_pv), 32'd1);
    pix_en = 0; step();

    // Blanking throughput: four queued writes, one ack every 2 clk.
    bright = 0; ack_q.delete(); we_count = 0;
    k = 0; s = cyc;
    cpu_req = 1; cpu_we = 1; cpu_addr = '0; cpu_wdata = DW'(1);
    for (int i = 0; i < 16 && k < 4; i++) begin
      pix_en = (i % 2 == 0);
      step();
      if (last_ack) begin
        k++;
        cpu_addr = AW'(k); cpu_wdata = DW'(k + 1);
        if (k == 4) cpu_req = 0;
      end
    end
    pix_en = 0; step();
    check("blank_acks", 32'(ack_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < ack_q.size(); i++)
      check("blank_ack_cycle", 32'(ack_q[i] - s), 32'(2 * i + 1));
    check("blank_we_count", 32'(we_count), 32'd4);
    for (int i = 0; i < 4; i++) check("blank_ram", 32'(ram[i]), 32'(i + 1));

    // Priority stall: request raised in a visible display slot.
    ack_q.delete();
    bright = 1; hcount = '0; vcount = '0;
    pix_en = 1; cpu_req = 1; cpu_we = 0; cpu_addr = AW'(100);
    s = cyc;
    step();
    check("stall_disp_addr", 32'(s_addr), 32'd0);
    pix_en = 0; step();
    check("stall_grant_addr", 32'(s_addr), 32'd100);
    pix_en = 1; step();
    if (last_ack) cpu_req = 0;
    check("stall_acks", 32'(ack_q.size()), 32'd1);
    if (ack_q.size() > 0) check("stall_ack_cycle", 32'(ack_q[0] - s), 32'd2);
    check("stall_rdata", 32'(s_rdata), 32'h1234);
    pix_en = 0; step();

    // Visible region with a back-to-back CPU read stream.
    ack_q.delete(); drops = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = AW'($urandom_range(0, 19199));
    vcount = 10'd37;
    for (int i = 0; i < 40; i++) begin
      pix_en = (i % 2 == 0);
      hcount = 10'(100 + i / 2);
      step();
      if (i >= 2 && !s_pv) drops++;
      if (last_ack) cpu_addr = AW'($urandom_range(0, 19199));
    end
    cpu_req = 0;
    check("vis_acks", 32'(ack_q.size()), 32'd19);
    check("vis_pv_drops", 32'(drops), 32'd0);
    pix_en = 0; step();

    // Reset in the cycle a write would be granted.
    bright = 0; pix_en = 0; ack_q.delete(); we_count = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = AW'(50); cpu_wdata = 16'h5A5A;
    reset = 1; step();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (last_ack) cpu_req = 0;
    end
    check("rst_mid_acks", 32'(ack_q.size()), 32'd1);
    check("rst_mid_we_count", 32'(we_count), 32'd1);
    check("rst_mid_ram", 32'(ram[50]), 32'h5A5A);

    // Randomized traffic.
    stuck = 0;
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (stuck > 0) begin
        stuck--; pix_en = 0;
      end else begin
        pix_en = (i % 2 == 0);
        if ($urandom_range(0, 99) == 0) stuck = int'($urandom_range(2, 12));
      end
      if ($urandom_range(0, 19) == 0) bright = ~bright;
      if (pix_en) begin
        hcount = 10'($urandom_range(0, 639));
        vcount = 10'($urandom_range(0, 479));
      end
      step();
      if (last_ack || !cpu_req) begin
        cpu_req = ($urandom_range(0, 2) != 0);
        cpu_we = $urandom_range(0, 1) != 0;
        cpu_addr = ($urandom_range(0, 3) == 0) ? s_addr : AW'($urandom_range(0, 19199));
        cpu_wdata = DW'($urandom);
      end
    end
    reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
